// File: rtl/iob_ram_be_arbiter.sv
// iob_ram_be_arbiter: two-master round-robin arbiter in front of one port
// of a byte-enabled, read-first RAM with 1-cycle read latency.
// Optional feature macro: IOB_RAM_ARB_CLR_EN (zero the whole RAM after reset
// before any access is granted).
//
// state | meaning
// ------+---------------------------------------------------------------
// CLR   | sweeping every address with zero, requests held off (macro only)
// ARB   | normal arbitration, init_done high
module iob_ram_be_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                r0_valid,
   input  logic [ADDR_W-1:0]   r0_addr,
   input  logic [DATA_W-1:0]   r0_wdata,
   input  logic [DATA_W/8-1:0] r0_wstrb,
   output logic                r0_ready,
   output logic                r0_rvalid,
   output logic [DATA_W-1:0]   r0_rdata,
   input  logic                r1_valid,
   input  logic [ADDR_W-1:0]   r1_addr,
   input  logic [DATA_W-1:0]   r1_wdata,
   input  logic [DATA_W/8-1:0] r1_wstrb,
   output logic                r1_ready,
   output logic                r1_rvalid,
   output logic [DATA_W-1:0]   r1_rdata,
   output logic                ram_en,
   output logic [DATA_W/8-1:0] ram_we,
   output logic [ADDR_W-1:0]   ram_addr,
   output logic [DATA_W-1:0]   ram_din,
   input  logic [DATA_W-1:0]   ram_dout,
   output logic                init_done
);

   logic inClr;
   logic arbEn;
   logic grant0;
   logic grant1;
   logic lastGrant;   // 1: r1 was granted last, so r0 wins the next contention

`ifdef IOB_RAM_ARB_CLR_EN
   typedef enum logic {CLR = 1'b0, ARB = 1'b1} state_t;

   state_t            state;
   state_t            stateNext;
   logic [ADDR_W-1:0] clrCnt;
   logic [ADDR_W-1:0] clrCntNext;

   // State register and sweep counter; reset always restarts the sweep at 0
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= CLR;
         clrCnt <= '0;
      end else begin
         state  <= stateNext;
         clrCnt <= clrCntNext;
      end
   end

   // Sweep advance; the last address hands over to ARB (counter wraps to 0)
   always_comb begin
      stateNext  = state;
      clrCntNext = clrCnt;
      if (state == CLR) begin
         clrCntNext = clrCnt + ADDR_W'(1);
         if (clrCnt == {ADDR_W{1'b1}}) stateNext = ARB;
      end
   end

   assign inClr = (state == CLR);
`else
   assign inClr = 1'b0;
`endif

   // While rst is high nothing is granted, even before the reset edge lands
   assign arbEn  = ~rst & ~inClr;
   assign grant0 = arbEn & r0_valid & (~r1_valid | lastGrant);
   assign grant1 = arbEn & r1_valid & (~r0_valid | ~lastGrant);

   // Round-robin pointer and per-requester read-valid pipeline
   always_ff @(posedge clk) begin
      if (rst) begin
         lastGrant <= 1'b1;
         r0_rvalid <= 1'b0;
         r1_rvalid <= 1'b0;
      end else begin
         if (grant0)      lastGrant <= 1'b0;
         else if (grant1) lastGrant <= 1'b1;
         r0_rvalid <= grant0 & ~|r0_wstrb;
         r1_rvalid <= grant1 & ~|r1_wstrb;
      end
   end

   // RAM port mux: granted requester, else the clear sweep, else idle
   always_comb begin
      r0_ready  = grant0;
      r1_ready  = grant1;
      init_done = arbEn;
      ram_en    = 1'b0;
      ram_we    = '0;
      ram_addr  = '0;
      ram_din   = '0;
      if (grant0) begin
         ram_en   = 1'b1;
         ram_we   = r0_wstrb;
         ram_addr = r0_addr;
         ram_din  = r0_wdata;
      end else if (grant1) begin
         ram_en   = 1'b1;
         ram_we   = r1_wstrb;
         ram_addr = r1_addr;
         ram_din  = r1_wdata;
      end
`ifdef IOB_RAM_ARB_CLR_EN
      else if (inClr && !rst) begin
         ram_en   = 1'b1;
         ram_we   = '1;
         ram_addr = clrCnt;
      end
`endif
   end

   assign r0_rdata = ram_dout;
   assign r1_rdata = ram_dout;

endmodule

// File: tb/tb_iob_ram_be_arbiter.sv
// Bench for iob_ram_be_arbiter with a small byte-enabled read-first RAM model.
// Clear-sweep checks are compiled in when IOB_RAM_ARB_CLR_EN is defined.
module tb_iob_ram_be_arbiter;
   localparam int AW = 4;
   localparam int DW = 32;
   localparam int NB = DW / 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          r0_valid = 1'b0, r1_valid = 1'b0;
   logic [AW-1:0] r0_addr = '0, r1_addr = '0;
   logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
   logic [NB-1:0] r0_wstrb = '0, r1_wstrb = '0;
   logic          r0_ready, r1_ready, r0_rvalid, r1_rvalid;
   logic [DW-1:0] r0_rdata, r1_rdata;
   logic          ram_en;
   logic [NB-1:0] ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout = '0;
   logic          init_done;

   always #5 clk = ~clk;

   iob_ram_be_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_wstrb(r0_wstrb),
      .r0_ready(r0_ready), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
      .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_wstrb(r1_wstrb),
      .r1_ready(r1_ready), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_dout(ram_dout), .init_done(init_done)
   );

   // RAM model: read-first, one cycle latency, power-up contents all ones
   logic [DW-1:0] mem [2**AW] = '{default: 32'hFFFF_FFFF};
   always @(posedge clk) begin
      if (ram_en) begin
         ram_dout <= mem[ram_addr];
         for (int b = 0; b < NB; b++)
            if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int nVec  = 0;
   int nFail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic          v0;
      logic [AW-1:0] a0;
      logic [DW-1:0] d0;
      logic [NB-1:0] s0;
      logic          v1;
      logic [AW-1:0] a1;
      logic [DW-1:0] d1;
      logic [NB-1:0] s1;
      logic          g0;
      logic          g1;
      logic [DW-1:0] ed;   // expected read data of the granted read
   } vec_t;

   typedef struct {
      int            who;
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   localparam int NV = 21;
   vec_t vecs [NV];
   exp_t q [$];

   logic          sbEn = 1'b0;
   logic          curG0 = 1'b0, curG1 = 1'b0;
   logic [DW-1:0] curEd = '0;

   // Scoreboard: compare rvalid/rdata against queued reads, then log this cycle's grant
   always @(negedge clk) begin
      logic e0, e1;
      if (sbEn) begin
         e0 = (q.size() > 0) && (q[0].due == cyc) && (q[0].who == 0);
         e1 = (q.size() > 0) && (q[0].due == cyc) && (q[0].who == 1);
         chk("r0_rvalid", 32'(r0_rvalid), 32'(e0));
         chk("r1_rvalid", 32'(r1_rvalid), 32'(e1));
         if ((q.size() > 0) && (q[0].due == cyc)) begin
            if (q[0].who == 0) chk("r0_rdata", r0_rdata, q[0].data);
            else               chk("r1_rdata", r1_rdata, q[0].data);
            void'(q.pop_front());
         end
         chk("r0_ready", 32'(r0_ready), 32'(curG0));
         chk("r1_ready", 32'(r1_ready), 32'(curG1));
         chk("ram_en", 32'(ram_en), 32'(curG0 | curG1));
         if (curG0) begin
            chk("ram_addr r0", 32'(ram_addr), 32'(r0_addr));
            chk("ram_we r0", 32'(ram_we), 32'(r0_wstrb));
            if (r0_wstrb != '0) chk("ram_din r0", ram_din, r0_wdata);
            else q.push_back('{0, curEd, cyc + 1});
         end else if (curG1) begin
            chk("ram_addr r1", 32'(ram_addr), 32'(r1_addr));
            chk("ram_we r1", 32'(ram_we), 32'(r1_wstrb));
            if (r1_wstrb != '0) chk("ram_din r1", ram_din, r1_wdata);
            else q.push_back('{1, curEd, cyc + 1});
         end else begin
            chk("ram_we idle", 32'(ram_we), 32'h0);
         end
      end
   end

`ifdef IOB_RAM_ARB_CLR_EN
   localparam logic [DW-1:0] EXP_INIT = 32'h0000_0000;
`else
   localparam logic [DW-1:0] EXP_INIT = 32'hFFFF_FFFF;
`endif

   initial begin
      //          v0    a0     d0             s0     v1    a1     d1             s1     g0    g1    ed
      vecs[0]  = '{1'b1, 4'd5, 32'hDEADBEEF, 4'hF, 1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 1'b0, 32'h0};
      vecs[1]  = '{1'b1, 4'd5, 32'h0,        4'h0, 1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 1'b0, 32'hDEADBEEF};
      vecs[2]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 1'b0, 32'h0};
      vecs[3]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd7, 32'h11223344, 4'hF, 1'b0, 1'b1, 32'h0};
      vecs[4]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd7, 32'hAABBCCDD, 4'h5, 1'b0, 1'b1, 32'h0};
      vecs[5]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd7, 32'h0,        4'h0, 1'b0, 1'b1, 32'h11BB33DD};
      vecs[6]  = '{1'b1, 4'd1, 32'h00000101, 4'hF, 1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 1'b0, 32'h0};
      vecs[7]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd2, 32'h00000202, 4'hF, 1'b0, 1'b1, 32'h0};
      vecs[8]  = '{1'b1, 4'd1, 32'h0,        4'h0, 1'b1, 4'd2, 32'h0,        4'h0, 1'b1, 1'b0, 32'h00000101};
      vecs[9]  = '{1'b1, 4'd1, 32'h0,        4'h0, 1'b1, 4'd2, 32'h0,        4'h0, 1'b0, 1'b1, 32'h00000202};
      vecs[10] = '{1'b1, 4'd1, 32'h0,        4'h0, 1'b1, 4'd2, 32'h0,        4'h0, 1'b1, 1'b0, 32'h00000101};
      vecs[11] = '{1'b1, 4'd1, 32'h0,        4'h0, 1'b1, 4'd2, 32'h0,        4'h0, 1'b0, 1'b1, 32'h00000202};
      vecs[12] = '{1'b1, 4'd3, 32'h00000001, 4'hF, 1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 1'b0, 32'h0};
      vecs[13] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd3, 32'h0,        4'h0, 1'b0, 1'b1, 32'h00000001};
      vecs[14] = '{1'b1, 4'd3, 32'h0,        4'h0, 1'b1, 4'd3, 32'h00000002, 4'hF, 1'b1, 1'b0, 32'h00000001};
      vecs[15] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd3, 32'h00000002, 4'hF, 1'b0, 1'b1, 32'h0};
      vecs[16] = '{1'b1, 4'd3, 32'h0,        4'h0, 1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 1'b0, 32'h00000002};
      vecs[17] = '{1'b1, 4'd5, 32'h0,        4'h0, 1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 1'b0, 32'hDEADBEEF};
      vecs[18] = '{1'b1, 4'd7, 32'h0,        4'h0, 1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 1'b0, 32'h11BB33DD};
      vecs[19] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 1'b0, 32'h0};
      vecs[20] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 1'b0, 32'h0};

      // Reset with both masters already requesting reads of address 9
      repeat (2) @(posedge clk);
      #1;
      r0_valid = 1'b1; r0_addr = 4'd9; r0_wstrb = 4'h0;
      r1_valid = 1'b1; r1_addr = 4'd9; r1_wstrb = 4'h0;
      @(negedge clk);
      chk("rst r0_ready", 32'(r0_ready), 32'h0);
      chk("rst r1_ready", 32'(r1_ready), 32'h0);
      chk("rst r0_rvalid", 32'(r0_rvalid), 32'h0);
      chk("rst r1_rvalid", 32'(r1_rvalid), 32'h0);
      chk("rst ram_en", 32'(ram_en), 32'h0);
      chk("rst ram_we", 32'(ram_we), 32'h0);
      chk("rst init_done", 32'(init_done), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
`ifdef IOB_RAM_ARB_CLR_EN
      for (int i = 0; i < 2**AW; i++) begin
         @(negedge clk);
         chk("clr ram_en", 32'(ram_en), 32'h1);
         chk("clr ram_we", 32'(ram_we), 32'hF);
         chk("clr ram_addr", 32'(ram_addr), 32'(i));
         chk("clr ram_din", ram_din, 32'h0);
         chk("clr init_done", 32'(init_done), 32'h0);
         chk("clr ready", 32'({r1_ready, r0_ready}), 32'h0);
      end
`endif
      // First arbitration cycle: held requests served, r0 wins the first contention
      @(negedge clk);
      chk("first init_done", 32'(init_done), 32'h1);
      chk("first r0_ready", 32'(r0_ready), 32'h1);
      chk("first r1_ready", 32'(r1_ready), 32'h0);
      chk("first ram_addr", 32'(ram_addr), 32'd9);
      chk("first ram_we", 32'(ram_we), 32'h0);
      @(posedge clk);
      #1 r0_valid = 1'b0;
      @(negedge clk);
      chk("first r0_rvalid", 32'(r0_rvalid), 32'h1);
      chk("first r0_rdata", r0_rdata, EXP_INIT);
      chk("first r1_rvalid", 32'(r1_rvalid), 32'h0);
      chk("second r1_ready", 32'(r1_ready), 32'h1);
      @(posedge clk);
      #1 r1_valid = 1'b0;
      @(negedge clk);
      chk("second r1_rvalid", 32'(r1_rvalid), 32'h1);
      chk("second r1_rdata", r1_rdata, EXP_INIT);
      chk("second r0_rvalid", 32'(r0_rvalid), 32'h0);

      // Table-driven single-cycle vectors
      for (int i = 0; i < NV; i++) begin
         @(posedge clk);
         #1;
         r0_valid = vecs[i].v0; r0_addr = vecs[i].a0; r0_wdata = vecs[i].d0; r0_wstrb = vecs[i].s0;
         r1_valid = vecs[i].v1; r1_addr = vecs[i].a1; r1_wdata = vecs[i].d1; r1_wstrb = vecs[i].s1;
         curG0 = vecs[i].g0; curG1 = vecs[i].g1; curEd = vecs[i].ed;
         sbEn = 1'b1;
      end
      @(posedge clk);
      #1 sbEn = 1'b0;
      chk("scoreboard drained", 32'(q.size()), 32'h0);

      // Reset the cycle after a read accept; pointer must return to favour r0
      r0_valid = 1'b1; r0_addr = 4'd5; r0_wstrb = 4'h0;
      @(negedge clk);
      chk("mid r0_ready", 32'(r0_ready), 32'h1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      r1_valid = 1'b1; r1_addr = 4'd5; r1_wstrb = 4'h0;
      @(negedge clk);
      chk("mid rst ready", 32'({r1_ready, r0_ready}), 32'h0);
      chk("mid rst ram_en", 32'(ram_en), 32'h0);
      @(posedge clk);
      @(negedge clk);
      chk("mid rst r0_rvalid", 32'(r0_rvalid), 32'h0);
      chk("mid rst r1_rvalid", 32'(r1_rvalid), 32'h0);
      chk("mid rst init_done", 32'(init_done), 32'h0);
      chk("mid rst ram_we", 32'(ram_we), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
`ifdef IOB_RAM_ARB_CLR_EN
      repeat (2**AW) @(posedge clk);
`endif
      @(negedge clk);
      chk("ptr reset r0_ready", 32'(r0_ready), 32'h1);
      chk("ptr reset r1_ready", 32'(r1_ready), 32'h0);
      @(posedge clk);
      #1 r0_valid = 1'b0;
      @(negedge clk);
      chk("ptr reset r1 next", 32'(r1_ready), 32'h1);
      chk("ptr reset r0_rvalid", 32'(r0_rvalid), 32'h1);
      @(posedge clk);
      #1 r1_valid = 1'b0;

`ifdef IOB_RAM_ARB_CLR_EN
      // Reset pulse at sweep address 6 restarts the sweep at 0
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("sweep addr", 32'(ram_addr), 32'(i));
      end
      @(negedge clk);
      chk("sweep addr 6", 32'(ram_addr), 32'd6);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("restart addr 0", 32'(ram_addr), 32'd0);
      chk("restart ram_we", 32'(ram_we), 32'hF);
      chk("restart init_done", 32'(init_done), 32'h0);
      @(negedge clk);
      chk("restart addr 1", 32'(ram_addr), 32'd1);
`endif
      repeat (20) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end

endmodule

// File: doc/iob_ram_be_arbiter.md
# iob_ram_be_arbiter

Two-requester round-robin arbiter that shares one port of the byte-enabled dual-port RAM (read-first, 1-cycle read latency) between two IOb-native-style masters. It accepts at most one transaction per cycle and routes read data back to the originating requester with a registered valid. It optionally clears the whole RAM to zero after reset before granting any access. It sits between the CPU/DMA-side interconnect and one RAM port; the other RAM port is untouched.

## Interface
- ADDR_W, 10, RAM address width; depth is 2**ADDR_W words
- DATA_W, 32, word width; multiple of 8; byte lanes = DATA_W/8
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- r0_valid / r1_valid  in  1  request valid, held until accepted
- r0_addr / r1_addr  in  ADDR_W  word address
- r0_wdata / r1_wdata  in  DATA_W  write data
- r0_wstrb / r1_wstrb  in  DATA_W/8  byte write strobes; all-zero = read
- r0_ready / r1_ready  out  1  request accepted this cycle (combinational)
- r0_rvalid / r1_rvalid  out  1  read data valid (registered)
- r0_rdata / r1_rdata  out  DATA_W  read data, both driven from ram_dout, qualified by rvalid
- ram_en  out  1  RAM port enable
- ram_we  out  DATA_W/8  RAM byte write enables
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM read data (1-cycle latency)
- init_done  out  1  high once arbitration is enabled

## Operation
- States: CLR (macro only), ARB. Reset enters CLR when the macro is defined, else ARB.
- CLR: ram_en=1, ram_we=all ones, ram_din=0, ram_addr=clr_cnt; clr_cnt counts 0 to 2**ADDR_W-1, then transitions to ARB. r0_ready=r1_ready=0, init_done=0.
- ARB: init_done=1. Grant goes to the sole valid requester. If both are valid, grant goes to the requester not granted last. The last-grant pointer resets to 1, so r0 wins the first contention. The pointer updates only on a grant.
- Granted requester: ready=1; ram_en=1, ram_addr/ram_din/ram_we = its addr/wdata/wstrb. No grant: ram_en=0, ram_we=0.
- A read (wstrb==0) accepted at cycle N sets that requester's rvalid at N+1 for exactly one cycle. Writes never produce rvalid.
- Partial strobes write only the selected bytes; unselected bytes are preserved by the RAM.

## Timing
- Reset values: r0/r1_ready=0, r0/r1_rvalid=0, ram_en=0, ram_we=0, init_done=0, clr_cnt=0, pointer=1.
- Throughput: 1 transaction/cycle. Back-to-back grants to the same requester are allowed when the other is idle.
- Read latency: accept at N, data at N+1. Data is read-first, i.e. the word before any write issued at N.
- Write at N followed by a read of the same address at N+1 (either requester) returns the new data.
- CLR lasts exactly 2**ADDR_W cycles after rst deasserts; the first grant is possible on the following cycle.
- rst asserted mid-CLR restarts the sweep at address 0.
- rst asserted while a read is outstanding drops its rvalid (cleared at the next edge).
- Requests arriving during CLR are held, not lost, since the master keeps valid high.

## Configuration
- IOB_RAM_ARB_CLR_EN defined: CLR sweep after every reset, init_done rises after 2**ADDR_W cycles.
- IOB_RAM_ARB_CLR_EN undefined: no CLR state, no clr_cnt; init_done=1 on the first cycle after reset, and RAM contents keep their $readmemh/power-up values.

## Test plan
- Single write then read: r0 writes 0xDEADBEEF at addr 5 with wstrb 0xF, then reads addr 5 -> r0_rvalid one cycle after accept, r0_rdata=0xDEADBEEF, r1_rvalid stays 0.
- Byte strobe: r1 writes 0x11223344 at addr 7 (wstrb 0xF), then 0xAABBCCDD with wstrb 0x5, then reads addr 7 -> 0x11BB33DD.
- Contention: r0 and r1 both hold valid reads for 4 cycles -> grants alternate r0,r1,r0,r1. Each requester sees rvalid only for its own read; no cycle grants both.
- Read-first: r0 writes 0x1 at addr 3 while r1 reads addr 3 in the next cycle, versus r0 reading addr 3 in the same cycle as an r1 write of 0x2 -> the same-cycle read returns old data, the next-cycle read returns new data.
- CLR (macro on, ADDR_W=4): preload 0xFFFFFFFF, release rst -> exactly 16 cycles of ram_we=0xF with ram_addr 0..15, then init_done=1, and a read of addr 9 returns 0. Pulsing rst at sweep address 6 restarts the sweep at 0.
- Reset mid-read: assert rst the cycle after a read accept -> rvalid=0 and ready=0 during reset; the pointer returns to 1 (r0 wins the first contention afterwards).
